accum_cpu_core: RTL and testbench
=================================

ACCUM_CPU_CORE -- requirements
Module: accum_cpu_core

Interface
REQ-001 SHALL have parameter DATA_W, default 18: accumulator, data word and instruction width.
REQ-002 SHALL have parameter ADDR_W, default 13: address and PC width; legal only when DATA_W >= ADDR_W+3.
REQ-003 SHALL have parameter LED_W, default 10: width of the led output, which is at most DATA_W.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge; there is one clock and no internal clock divider.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port run, input, 1 bit: permits a new instruction fetch to start.
REQ-007 SHALL have port mem_req, output, 1 bit: memory transaction request.
REQ-008 SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port mem_addr, output, ADDR_W bits: transaction address.
REQ-010 SHALL have port mem_wdata, output, DATA_W bits: write data, equal to AC.
REQ-011 SHALL have port mem_rdata, input, DATA_W bits: read data, valid when mem_ack=1.
REQ-012 SHALL have port mem_ack, input, 1 bit: transaction completes on a rising edge where mem_req=1 and mem_ack=1.
REQ-013 SHALL have port acc_out, output, DATA_W bits: accumulator.
REQ-014 SHALL have port pc_out, output, ADDR_W bits: program counter.
REQ-015 SHALL have port flags, output, 3 bits: {ovf, neg, zero}.
REQ-016 SHALL have port halted, output, 1 bit: high while in HALT.
REQ-017 SHALL have port led, output, LED_W bits: registered copy of AC[LED_W-1:0].

Function
REQ-018 Instruction format SHALL be: opcode = bits [DATA_W-1:DATA_W-3]; operand address = bits [ADDR_W-1:0]; other bits ignored.
REQ-019 Opcodes SHALL be: 0 HLT, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 JMP, 7 JZ; all 8 are legal.
REQ-020 FSM states SHALL be FETCH, DECODE, MEM_RD, MEM_WR, HALT.
REQ-021 FETCH SHALL behave as follows: mem_req=run, mem_we=0, mem_addr=PC; on completion IR<=mem_rdata, PC<=PC+1 mod 2^ADDR_W, next state DECODE; otherwise stay in FETCH.
REQ-022 DECODE SHALL take one cycle with mem_req=0, with these next states:
- HLT -> HALT.
- JMP -> PC<=addr, then FETCH.
- JZ -> PC<=addr if zero=1, else PC unchanged, then FETCH.
- LDA, ADD, SUB, AND -> MEM_RD.
- STA -> MEM_WR.
REQ-023 MEM_RD SHALL drive mem_req=1, mem_we=0, mem_addr=IR addr. On completion:
- LDA: AC<=rdata.
- ADD: AC<=AC+rdata.
- SUB: AC<=AC-rdata.
- AND: AC<=AC&rdata.
- Then go to FETCH.
REQ-024 MEM_WR SHALL drive mem_req=1, mem_we=1, mem_addr=IR addr, mem_wdata=AC; on completion go to FETCH.
REQ-025 HALT SHALL keep mem_req=0 and halted=1; only reset leaves HALT.
REQ-026 While mem_req=1 and mem_ack=0, mem_addr, mem_we and mem_wdata SHALL stay stable, and no register SHALL update.
REQ-027 mem_ack SHALL be ignored when mem_req=0.
REQ-028 Back-to-back requests SHALL be allowed: a completion in MEM_RD or MEM_WR may be followed directly by a FETCH request.
REQ-029 With zero-wait memory (ack in the same cycle as req) and run=1, latency SHALL be:
- LDA, ADD, SUB, AND, STA: 3 cycles.
- JMP, JZ: 2 cycles.
- Each ack wait cycle adds 1 cycle.
REQ-030 Arithmetic SHALL be modulo 2^DATA_W.
REQ-031 ovf SHALL be signed two's-complement overflow of ADD/SUB, and SHALL be cleared by LDA and AND.
REQ-032 neg SHALL equal AC[DATA_W-1], and zero SHALL equal (AC==0).
REQ-033 Flags SHALL update only on completion of LDA, ADD, SUB or AND, and SHALL be computed from the new AC.
REQ-034 run=0 SHALL stall only in FETCH (mem_req=0 there); a transaction already in MEM_RD/MEM_WR SHALL complete regardless of run.
REQ-035 led SHALL update one cycle after AC changes.

Reset
REQ-036 On a rising edge with reset=1 the block SHALL set state=FETCH, PC=0, IR=0, AC=0, flags=0, led=0, halted=0.
REQ-037 In the cycle after that reset edge, mem_req SHALL be 0 and mem_we SHALL be 0.
REQ-038 Reset SHALL take priority over any mem_ack in the same cycle, and an interrupted transaction SHALL be abandoned without register update.

Verification
REQ-039 The bench SHALL cover, with DATA_W=18, ADDR_W=13 and zero-wait memory: program 0x08010, 0x18011, 0x10012, 0x00000 with mem[0x10]=5, mem[0x11]=7 -> mem[0x12]=12, AC=12, PC=4, halted=1, flags=000, after 11 cycles of run=1.
REQ-040 The bench SHALL cover: mem[0x10]=0x1FFFF, mem[0x11]=1, LDA 0x10 then ADD 0x11 -> AC=0x20000, flags=110; then SUB 0x11 -> AC=0x1FFFF, flags=100.
REQ-041 The bench SHALL cover: LDA of a location holding 0, then JZ 0x20 at address 1 -> next fetch mem_addr=0x20; with a location holding 3 instead -> next fetch mem_addr=2.
REQ-042 The bench SHALL cover: mem_ack delayed 3 cycles on every request -> mem_req, mem_addr, mem_we, mem_wdata stable for 4 cycles, exactly one AC/PC update per transaction.
REQ-043 The bench SHALL cover: reset asserted during MEM_WR with mem_ack=1 in the same cycle -> no write counted, next cycle mem_req=0, PC=0, AC=0; with run held 0 afterwards, mem_req stays 0.
REQ-044 The bench SHALL cover: JMP 0x1FFF, then fetch of mem[0x1FFF]=0x18000 (ADD 0x0000) -> PC wraps to 0x0000 after that fetch.

Source files
------------

// File: rtl/accum_cpu_core.sv
// Accumulator CPU core: five-state fetch/decode/execute machine driving a
// single-ported req/ack memory bus. AC, PC, flags and led are registered;
// the bus request signals are decoded from the registered state.
module accum_cpu_core #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 13,
  parameter int LED_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [2:0]        flags,
  output logic              halted,
  output logic [LED_W-1:0]  led
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_STA = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_JZ  = 3'd7;

  localparam int MSB = DATA_W - 1;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [2:0]         ir_op;
  logic [ADDR_W-1:0]  ir_addr;
  logic [DATA_W-1:0]  acc;
  logic               ovf;
  logic               neg;
  logic               zero;
  logic [LED_W-1:0]   led_q;
  // Cleared by reset so the bus stays idle for one cycle after reset even
  // when run is already high.
  logic               armed;

  logic               bus_done;
  logic [DATA_W-1:0]  sum;
  logic [DATA_W-1:0]  diff;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_ovf;

  assign bus_done  = mem_req & mem_ack;
  assign mem_wdata = acc;
  assign acc_out   = acc;
  assign pc_out    = pc;
  assign flags     = {ovf, neg, zero};
  assign halted    = (state == HALT);
  assign led       = led_q;

  // Bus request decode: only FETCH depends on run, data phases always request.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = ir_addr;
    case (state)
      FETCH: begin
        mem_req  = run & armed;
        mem_addr = pc;
      end
      MEM_RD: mem_req = 1'b1;
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU result for the data-read instructions, with signed overflow detection.
  always_comb begin
    sum        = acc + mem_rdata;
    diff       = acc - mem_rdata;
    alu_result = mem_rdata;
    alu_ovf    = 1'b0;
    case (ir_op)
      OP_ADD: begin
        alu_result = sum;
        alu_ovf    = (acc[MSB] == mem_rdata[MSB]) && (sum[MSB] != acc[MSB]);
      end
      OP_SUB: begin
        alu_result = diff;
        alu_ovf    = (acc[MSB] != mem_rdata[MSB]) && (diff[MSB] != acc[MSB]);
      end
      OP_AND:  alu_result = acc & mem_rdata;
      default: ;
    endcase
  end

  // Control FSM and architectural registers; nothing advances while a bus
  // request waits for its acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= '0;
      ir_op   <= '0;
      ir_addr <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      neg     <= 1'b0;
      zero    <= 1'b0;
      led_q   <= '0;
      armed   <= 1'b0;
    end else begin
      armed <= 1'b1;
      led_q <= acc[LED_W-1:0];
      case (state)
        FETCH: begin
          if (bus_done) begin
            ir_op   <= mem_rdata[DATA_W-1 -: 3];
            ir_addr <= mem_rdata[ADDR_W-1:0];
            pc      <= pc + ADDR_W'(1);
            state   <= DECODE;
          end
        end
        DECODE: begin
          case (ir_op)
            OP_HLT: state <= HALT;
            OP_JMP: begin
              pc    <= ir_addr;
              state <= FETCH;
            end
            OP_JZ: begin
              if (zero) pc <= ir_addr;
              state <= FETCH;
            end
            OP_STA:  state <= MEM_WR;
            default: state <= MEM_RD;
          endcase
        end
        MEM_RD: begin
          if (bus_done) begin
            acc   <= alu_result;
            ovf   <= alu_ovf;
            neg   <= alu_result[MSB];
            zero  <= (alu_result == '0);
            state <= FETCH;
          end
        end
        MEM_WR: begin
          if (bus_done) state <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_cpu_core.sv
// Self-checking bench for accum_cpu_core: a memory responder with zero-wait,
// fixed-wait and random acknowledge modes, an instruction-level reference
// model checked every cycle, and directed programs with literal expectations.
module tb_accum_cpu_core;

  localparam int STEP_IDLE  = 0;
  localparam int STEP_READ  = 1;
  localparam int STEP_WRITE = 2;

  logic        clk;
  logic        reset;
  logic        run;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [17:0] mem_wdata;
  logic [17:0] mem_rdata;
  logic        mem_ack;
  logic [17:0] acc_out;
  logic [12:0] pc_out;
  logic [2:0]  flags;
  logic        halted;
  logic [9:0]  led;

  // Memory seen by the DUT and the responder's acknowledge control
  logic [17:0] ram [0:8191];
  int          ack_mode;
  int          wait_n;
  int          wait_cnt;
  logic        rand_ack;
  int          write_count;

  // Reference model state
  logic [17:0] m_mem [0:8191];
  logic [17:0] m_acc;
  logic [12:0] m_pc;
  logic        m_ovf;
  logic        m_neg;
  logic        m_zero;
  logic [9:0]  m_led;
  bit          m_halt;
  bit          m_armed;
  logic [2:0]  m_op;
  logic [12:0] m_arg;
  int          steps[$];
  bit          model_valid;

  // Values sampled just before each rising edge
  logic        c_run, c_reset, c_ack, d_req, d_we;
  logic [12:0] d_addr;
  logic [17:0] d_wdata;
  bit          was_waiting;

  int errors;
  int checks;

  assign mem_rdata = ram[mem_addr];
  assign mem_ack   = (ack_mode == 0) ? 1'b1 :
                     (ack_mode == 1) ? (wait_cnt >= wait_n) : rand_ack;

  accum_cpu_core #(.DATA_W(18), .ADDR_W(13), .LED_W(10)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .acc_out(acc_out), .pc_out(pc_out), .flags(flags),
    .halted(halted), .led(led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int to_signed(logic [17:0] v);
    return v[17] ? int'(v) - 262144 : int'(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit rn);
    reset = rst;
    run   = rn;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) begin
      ram[i]   = '0;
      m_mem[i] = '0;
    end
  endtask

  task automatic poke(input int addr, input logic [17:0] data);
    ram[addr]   = data;
    m_mem[addr] = data;
  endtask

  // Instruction-level model: an instruction is a fetch followed by a queue
  // of remaining steps (one idle decode step, then possibly a data access).
  task automatic model_step();
    logic [17:0] word, d, new_acc, old_acc;
    int a, b, r;
    if (c_reset) begin
      m_acc = '0; m_pc = '0; m_ovf = 0; m_neg = 0; m_zero = 0; m_led = '0;
      m_halt = 0; m_armed = 0; m_op = '0; m_arg = '0;
      steps.delete();
      model_valid = 1;
      return;
    end
    old_acc = m_acc;
    if (!m_halt) begin
      if (steps.size() == 0) begin
        if (m_armed && c_run && c_ack) begin
          word  = m_mem[m_pc];
          m_op  = word[17:15];
          m_arg = word[12:0];
          m_pc  = m_pc + 13'd1;
          steps.push_back(STEP_IDLE);
        end
      end else if (steps[0] == STEP_IDLE) begin
        steps.delete(0);
        case (m_op)
          3'd0:    m_halt = 1;
          3'd6:    m_pc = m_arg;
          3'd7:    if (m_zero) m_pc = m_arg;
          3'd2:    steps.push_back(STEP_WRITE);
          default: steps.push_back(STEP_READ);
        endcase
      end else if (steps[0] == STEP_READ) begin
        if (c_ack) begin
          d = m_mem[m_arg];
          a = to_signed(m_acc);
          b = to_signed(d);
          case (m_op)
            3'd1: begin new_acc = d; m_ovf = 0; end
            3'd3: begin r = a + b; new_acc = 18'(r); m_ovf = (r > 131071) || (r < -131072); end
            3'd4: begin r = a - b; new_acc = 18'(r); m_ovf = (r > 131071) || (r < -131072); end
            default: begin new_acc = m_acc & d; m_ovf = 0; end
          endcase
          m_acc  = new_acc;
          m_neg  = to_signed(new_acc) < 0;
          m_zero = (new_acc == 0);
          steps.delete(0);
        end
      end else begin
        if (c_ack) begin
          m_mem[m_arg] = m_acc;
          steps.delete(0);
        end
      end
    end
    m_led   = old_acc[9:0];
    m_armed = 1;
  endtask

  task automatic compare_cycle();
    bit e_req, e_we;
    logic [12:0] e_addr;
    if (!model_valid) return;
    e_req = 0; e_we = 0; e_addr = '0;
    if (m_halt) begin
      e_req = 0;
    end else if (steps.size() == 0) begin
      e_req  = m_armed && (run == 1'b1);
      e_addr = m_pc;
    end else if (steps[0] == STEP_READ) begin
      e_req = 1; e_addr = m_arg;
    end else if (steps[0] == STEP_WRITE) begin
      e_req = 1; e_we = 1; e_addr = m_arg;
    end
    checkOutput("cyc_req", 32'(mem_req), 32'(e_req));
    checkOutput("cyc_we", 32'(mem_we), 32'(e_we));
    if (e_req) checkOutput("cyc_addr", 32'(mem_addr), 32'(e_addr));
    if (e_req && e_we) checkOutput("cyc_wdata", 32'(mem_wdata), 32'(m_acc));
    checkOutput("cyc_acc", 32'(acc_out), 32'(m_acc));
    checkOutput("cyc_pc", 32'(pc_out), 32'(m_pc));
    checkOutput("cyc_flags", 32'(flags), 32'({m_ovf, m_neg, m_zero}));
    checkOutput("cyc_halted", 32'(halted), 32'(m_halt));
    checkOutput("cyc_led", 32'(led), 32'(m_led));
    if (was_waiting && !c_reset) begin
      checkOutput("hold_addr", 32'(mem_addr), 32'(d_addr));
      checkOutput("hold_we", 32'(mem_we), 32'(d_we));
      checkOutput("hold_wdata", 32'(mem_wdata), 32'(d_wdata));
    end
  endtask

  // One clock cycle: inputs already applied at the falling edge
  task automatic cycle();
    #3;
    compare_cycle();
    c_run = run; c_reset = reset; c_ack = mem_ack;
    d_req = mem_req; d_we = mem_we; d_addr = mem_addr; d_wdata = mem_wdata;
    @(posedge clk);
    #1;
    was_waiting = d_req && !c_ack && model_valid;
    if (c_reset) begin
      wait_cnt = 0;
    end else if (d_req && c_ack) begin
      if (d_we) begin
        ram[d_addr] = d_wdata;
        write_count++;
      end
      wait_cnt = 0;
    end else if (d_req) begin
      wait_cnt++;
    end
    model_step();
    if (ack_mode == 2) rand_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic start_program();
    applyStimulus(1, 0); cycle(); cycle();
    applyStimulus(0, 0); cycle();
    applyStimulus(0, 1);
  endtask

  initial begin
    int writes_before;
    logic [17:0] w;
    errors = 0; checks = 0; write_count = 0;
    ack_mode = 0; wait_n = 0; wait_cnt = 0; rand_ack = 1'b1;
    model_valid = 0; was_waiting = 0;
    applyStimulus(1, 0);
    clear_mem();
    @(negedge clk);

    // Reset state, including an idle bus in the cycle after reset with run high
    applyStimulus(1, 1); cycle();
    applyStimulus(0, 1);
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_we", 32'(mem_we), 32'd0);
    checkOutput("rst_acc", 32'(acc_out), 32'd0);
    checkOutput("rst_pc", 32'(pc_out), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_led", 32'(led), 32'd0);
    cycle();

    // Small program on zero-wait memory: 5 + 7 stored to 0x12, then halt
    clear_mem();
    poke(0, 18'h08010); poke(1, 18'h18011); poke(2, 18'h10012); poke(3, 18'h00000);
    poke(16'h10, 18'd5); poke(16'h11, 18'd7);
    start_program();
    repeat (10) cycle();
    checkOutput("prog_not_yet_halted", 32'(halted), 32'd0);
    cycle();
    checkOutput("prog_halted", 32'(halted), 32'd1);
    checkOutput("prog_acc", 32'(acc_out), 32'd12);
    checkOutput("prog_pc", 32'(pc_out), 32'd4);
    checkOutput("prog_flags", 32'(flags), 32'd0);
    checkOutput("prog_mem12", 32'(ram[16'h12]), 32'd12);
    checkOutput("prog_led", 32'(led), 32'd12);

    // Same program with three wait cycles on every request
    clear_mem();
    poke(0, 18'h08010); poke(1, 18'h18011); poke(2, 18'h10012); poke(3, 18'h00000);
    poke(16'h10, 18'd5); poke(16'h11, 18'd7);
    ack_mode = 1; wait_n = 3;
    start_program();
    writes_before = write_count;
    repeat (31) cycle();
    checkOutput("wait_not_yet_halted", 32'(halted), 32'd0);
    cycle();
    checkOutput("wait_halted", 32'(halted), 32'd1);
    checkOutput("wait_acc", 32'(acc_out), 32'd12);
    checkOutput("wait_pc", 32'(pc_out), 32'd4);
    checkOutput("wait_mem12", 32'(ram[16'h12]), 32'd12);
    checkOutput("wait_write_count", 32'(write_count - writes_before), 32'd1);
    ack_mode = 0;

    // Overflow and sign flags around the positive limit
    clear_mem();
    poke(0, 18'h08010); poke(1, 18'h18011); poke(2, 18'h20011); poke(3, 18'h00000);
    poke(16'h10, 18'h1FFFF); poke(16'h11, 18'd1);
    start_program();
    repeat (6) cycle();
    checkOutput("ovf_add_acc", 32'(acc_out), 32'h20000);
    checkOutput("ovf_add_flags", 32'(flags), 32'b110);
    repeat (3) cycle();
    checkOutput("ovf_sub_acc", 32'(acc_out), 32'h1FFFF);
    checkOutput("ovf_sub_flags", 32'(flags), 32'b100);

    // JZ taken and not taken
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      poke(0, 18'h08010); poke(1, 18'h38020);
      poke(16'h10, (k == 0) ? 18'd0 : 18'd3);
      start_program();
      repeat (5) cycle();
      checkOutput("jz_req", 32'(mem_req), 32'd1);
      checkOutput("jz_fetch_addr", 32'(mem_addr), (k == 0) ? 32'h20 : 32'h2);
    end

    // JMP to the top address, then PC wraps after fetching there
    clear_mem();
    poke(0, 18'h31FFF); poke(16'h1FFF, 18'h18000);
    start_program();
    repeat (2) cycle();
    checkOutput("wrap_jmp_pc", 32'(pc_out), 32'h1FFF);
    cycle();
    checkOutput("wrap_pc", 32'(pc_out), 32'h0);
    repeat (2) cycle();
    checkOutput("wrap_add_acc", 32'(acc_out), 32'h31FFF);
    checkOutput("wrap_add_flags", 32'(flags), 32'b010);

    // Reset arriving while a write is being acknowledged
    clear_mem();
    poke(0, 18'h08010); poke(1, 18'h10030); poke(16'h10, 18'd9);
    start_program();
    repeat (5) cycle();
    checkOutput("rw_in_write_we", 32'(mem_we), 32'd1);
    checkOutput("rw_in_write_addr", 32'(mem_addr), 32'h30);
    applyStimulus(1, 1);
    cycle();
    applyStimulus(0, 0);
    checkOutput("rw_req", 32'(mem_req), 32'd0);
    checkOutput("rw_pc", 32'(pc_out), 32'd0);
    checkOutput("rw_acc", 32'(acc_out), 32'd0);
    checkOutput("rw_mem30", 32'(ram[16'h30]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      checkOutput("rw_idle_req", 32'(mem_req), 32'd0);
    end

    // Random programs, random run and reset, random acknowledge delays
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 8192; i++) begin
        w = 18'($urandom);
        if (w[17:15] == 3'd0 && $urandom_range(0, 3) != 0) w[17:15] = 3'd3;
        poke(i, w);
      end
      ack_mode = (phase == 0) ? 2 : 0;
      start_program();
      for (int i = 0; i < 1200; i++) begin
        applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
